rpn_eval_core: RTL and testbench

Parametrised postfix (RPN) expression evaluator for the infix-to-postfix datapath. Accepts a stream of operands and operator codes over strobe handshakes and evaluates them on an internal operand stack. On an end-of-expression strobe it emits the result, or flags an error with a code. Generalises the earlier 8-bit evaluator in these ways:
- width and depth are parameters;
- iterative divide/modulo;
- full error detection;
- explicit BUSY back-pressure.

---
 rtl/rpn_eval_core.sv | 275 +++++++++++++++++++++++++++
 tb/tb_rpn_eval_core.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_eval_core.sv
// rpn_eval_core: postfix (RPN) expression evaluator with an internal operand stack.
//
// Operands are pushed with NUM_STB. Each OP_STB pops two entries and pushes the
// result: a = entry below top, b = top, result = a op b. The operators are
// "+", "-" and "*" (result wraps to WIDTH bits), "/" and "%" (unsigned). END_STB
// emits the single remaining entry on RESULT with a RESULT_STB pulse. Malformed
// input raises ERR_STB with a cause on ERR_CODE, clears the stack, and (except
// for an error at END) discards input until the next END_STB.
//
// Ports
//   CLK, RST          clock (rising edge) and asynchronous active-low reset
//   NUM_DATA/NUM_STB  operand value and push strobe
//   OP_CODE/OP_STB    ASCII operator and execute strobe
//   END_STB           end of expression
//   BUSY              strobes are ignored while high
//   RESULT/RESULT_STB result value (held between pulses) and one-cycle pulse
//   ERR_STB/ERR_CODE  one-cycle error pulse and held cause:
//                     1 underflow, 2 overflow, 3 divide by zero,
//                     4 bad operator, 5 END with depth != 1, 6 strobe collision
//   DEPTH_OUT         current stack occupancy
module rpn_eval_core #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] NUM_DATA,
  input  logic             NUM_STB,
  input  logic [7:0]       OP_CODE,
  input  logic             OP_STB,
  input  logic             END_STB,
  output logic             BUSY,
  output logic [WIDTH-1:0] RESULT,
  output logic             RESULT_STB,
  output logic             ERR_STB,
  output logic [2:0]       ERR_CODE,
  output logic [PW-1:0]    DEPTH_OUT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ALU, S_DIV, S_DRAIN} state_e;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD} op_e;

  localparam logic [2:0] E_UNDER = 3'd1;
  localparam logic [2:0] E_OVER  = 3'd2;
  localparam logic [2:0] E_DIVZ  = 3'd3;
  localparam logic [2:0] E_BADOP = 3'd4;
  localparam logic [2:0] E_END   = 3'd5;
  localparam logic [2:0] E_MULTI = 3'd6;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [PW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_stb_q, result_stb_d;
  logic             err_stb_q, err_stb_d;
  logic [2:0]       err_code_q, err_code_d;

  // Operand stack storage and its single write port.
  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  // Top (b) and the entry below it (a); indices wrap harmlessly when shallow.
  logic [AW-1:0]    top_idx, nxt_idx;
  logic [WIDTH-1:0] top_val, nxt_val;
  assign top_idx = AW'(sp_q - PW'(1));
  assign nxt_idx = AW'(sp_q - PW'(2));
  assign top_val = stack_mem[top_idx];
  assign nxt_val = stack_mem[nxt_idx];

  // Operator decode.
  logic op_valid;
  op_e  op_dec;
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    op_valid = 1'b1;
    op_dec   = OP_ADD;
    case (OP_CODE)
      8'h2B:   op_dec = OP_ADD;   // "+"
      8'h2D:   op_dec = OP_SUB;   // "-"
      8'h2A:   op_dec = OP_MUL;   // "*"
      8'h2F:   op_dec = OP_DIV;   // "/"
      8'h25:   op_dec = OP_MOD;   // "%"
      default: op_valid = 1'b0;
    endcase
  end

  // Single-cycle operators.
  logic [WIDTH-1:0] alu_res;
  always_comb begin
    case (op_q)
      OP_SUB:  alu_res = nxt_val - top_val;
      OP_MUL:  alu_res = nxt_val * top_val;
      default: alu_res = nxt_val + top_val;
    endcase
  end

  // One restoring-division step: the dividend shifts out of quo_q MSB-first
  // into the partial remainder while quotient bits shift in from the bottom.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] rem_next, quo_next;
  always_comb begin
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, dvsr_q};
    rem_next  = div_ge ? WIDTH'(div_shift - {1'b0, dvsr_q}) : div_shift[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], div_ge};
  end

  logic multi_stb;
  assign multi_stb = (NUM_STB & OP_STB) | (NUM_STB & END_STB) | (OP_STB & END_STB);

  logic       err;
  logic [2:0] err_val;
  logic       err_to_idle;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    sp_d         = sp_q;
    cnt_d        = cnt_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    dvsr_d       = dvsr_q;
    result_d     = result_q;
    result_stb_d = 1'b0;
    err_stb_d    = 1'b0;
    err_code_d   = err_code_q;
    we           = 1'b0;
    waddr        = AW'(sp_q);
    wdata        = NUM_DATA;
    err          = 1'b0;
    err_val      = 3'd0;
    err_to_idle  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (multi_stb) begin
          err         = 1'b1;
          err_val     = E_MULTI;
          err_to_idle = END_STB;  // expression already terminated
        end else if (NUM_STB) begin
          if (sp_q == PW'(DEPTH)) begin
            err     = 1'b1;
            err_val = E_OVER;
          end else begin
            we   = 1'b1;
            sp_d = sp_q + PW'(1);
          end
        end else if (OP_STB) begin
          if (sp_q < PW'(2)) begin
            err     = 1'b1;
            err_val = E_UNDER;
          end else if (!op_valid) begin
            err     = 1'b1;
            err_val = E_BADOP;
          end else if (op_dec == OP_DIV || op_dec == OP_MOD) begin
            if (top_val == '0) begin
              err     = 1'b1;
              err_val = E_DIVZ;
            end else begin
              op_d    = op_dec;
              state_d = S_DIV;
              cnt_d   = CW'(WIDTH - 1);
              quo_d   = nxt_val;
              rem_d   = '0;
              dvsr_d  = top_val;
            end
          end else begin
            op_d    = op_dec;
            state_d = S_ALU;
          end
        end else if (END_STB) begin
          if (sp_q == PW'(1)) begin
            result_d     = top_val;
            result_stb_d = 1'b1;
            sp_d         = '0;
          end else begin
            err         = 1'b1;
            err_val     = E_END;
            err_to_idle = 1'b1;
          end
        end
      end

      S_ALU: begin
        we      = 1'b1;
        waddr   = nxt_idx;
        wdata   = alu_res;
        sp_d    = sp_q - PW'(1);
        state_d = S_IDLE;
      end

      S_DIV: begin
        quo_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          we      = 1'b1;
          waddr   = nxt_idx;
          wdata   = (op_q == OP_MOD) ? rem_next : quo_next;
          sp_d    = sp_q - PW'(1);
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        if (END_STB) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (err) begin
      err_stb_d  = 1'b1;
      err_code_d = err_val;
      sp_d       = '0;
      state_d    = err_to_idle ? S_IDLE : S_DRAIN;
    end
  end

  // NOTE: the stack array has no reset; occupancy is tracked by sp_q alone, so
  // stale contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (we) stack_mem[waddr] <= wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      op_q         <= OP_ADD;
      sp_q         <= '0;
      cnt_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      dvsr_q       <= '0;
      result_q     <= '0;
      result_stb_q <= 1'b0;
      err_stb_q    <= 1'b0;
      err_code_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      sp_q         <= sp_d;
      cnt_q        <= cnt_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      dvsr_q       <= dvsr_d;
      result_q     <= result_d;
      result_stb_q <= result_stb_d;
      err_stb_q    <= err_stb_d;
      err_code_q   <= err_code_d;
    end
  end

  assign BUSY       = (state_q == S_ALU) || (state_q == S_DIV);
  assign RESULT     = result_q;
  assign RESULT_STB = result_stb_q;
  assign ERR_STB    = err_stb_q;
  assign ERR_CODE   = err_code_q;
  assign DEPTH_OUT  = sp_q;

endmodule

// File: tb/tb_rpn_eval_core.sv
// Self-checking bench for rpn_eval_core (WIDTH=32, DEPTH=16).
// A queue-based expression model predicts all outputs every cycle; directed
// sequences additionally pin results and error codes to hand-computed values.
module tb_rpn_eval_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] num_data;
  logic        num_stb;
  logic [7:0]  op_code;
  logic        op_stb;
  logic        end_stb;
  logic        busy;
  logic [31:0] result;
  logic        result_stb;
  logic        err_stb;
  logic [2:0]  err_code;
  logic [4:0]  depth_out;

  rpn_eval_core #(.WIDTH(32), .DEPTH(16)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .NUM_DATA   (num_data),
    .NUM_STB    (num_stb),
    .OP_CODE    (op_code),
    .OP_STB     (op_stb),
    .END_STB    (end_stb),
    .BUSY       (busy),
    .RESULT     (result),
    .RESULT_STB (result_stb),
    .ERR_STB    (err_stb),
    .ERR_CODE   (err_code),
    .DEPTH_OUT  (depth_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_stk[$];
  int          m_busy;     // cycles of BUSY still to come
  logic [31:0] m_pend;     // value replacing a,b once BUSY ends
  bit          m_drain;
  logic [31:0] e_result;
  bit          e_rstb;
  bit          e_estb;
  logic [2:0]  e_code;

  task automatic m_err(input logic [2:0] c, input bit to_drain);
    e_estb = 1'b1;
    e_code = c;
    m_stk.delete();
    m_drain = to_drain;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stk.delete();
      m_busy   = 0;
      m_drain  = 1'b0;
      e_result = 32'd0;
      e_rstb   = 1'b0;
      e_estb   = 1'b0;
      e_code   = 3'd0;
    end else begin
      logic [31:0] a, b;
      e_rstb = 1'b0;
      e_estb = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          void'(m_stk.pop_back());
          void'(m_stk.pop_back());
          m_stk.push_back(m_pend);
        end
      end else if (m_drain) begin
        if (end_stb) m_drain = 1'b0;
      end else if (int'(num_stb) + int'(op_stb) + int'(end_stb) > 1) begin
        m_err(3'd6, !end_stb);
      end else if (num_stb) begin
        if (m_stk.size() == 16) m_err(3'd2, 1'b1);
        else m_stk.push_back(num_data);
      end else if (op_stb) begin
        if (m_stk.size() < 2) m_err(3'd1, 1'b1);
        else begin
          a = m_stk[m_stk.size() - 2];
          b = m_stk[m_stk.size() - 1];
          case (op_code)
            "+": begin m_pend = a + b; m_busy = 1; end
            "-": begin m_pend = a - b; m_busy = 1; end
            "*": begin m_pend = a * b; m_busy = 1; end
            "/": if (b == 0) m_err(3'd3, 1'b1); else begin m_pend = a / b; m_busy = 32; end
            "%": if (b == 0) m_err(3'd3, 1'b1); else begin m_pend = a % b; m_busy = 32; end
            default: m_err(3'd4, 1'b1);
          endcase
        end
      end else if (end_stb) begin
        if (m_stk.size() == 1) begin
          e_result = m_stk[0];
          e_rstb   = 1'b1;
          m_stk.delete();
        end else m_err(3'd5, 1'b0);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] got_res[$];
  logic [2:0]  got_err[$];

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_busy",   32'(busy),       32'(m_busy > 0));
      check("cyc_depth",  32'(depth_out),  32'(m_stk.size()));
      check("cyc_rstb",   32'(result_stb), 32'(e_rstb));
      check("cyc_result", result,          e_result);
      check("cyc_estb",   32'(err_stb),    32'(e_estb));
      check("cyc_ecode",  32'(err_code),   32'(e_code));
      if (result_stb) got_res.push_back(result);
      if (err_stb) got_err.push_back(err_code);
    end
  end

  // ---------------- stimulus helpers (entered and left at negedge) ----------------
  task automatic strobe(input bit n, input bit o, input bit e, input logic [31:0] d, input logic [7:0] c);
    num_stb = n; op_stb = o; end_stb = e; num_data = d; op_code = c;
    @(negedge clk);
    num_stb = 1'b0; op_stb = 1'b0; end_stb = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: BUSY still 1 after %0d cycles", n);
    end
  endtask

  task automatic push(input logic [31:0] v);
    wait_idle();
    strobe(1'b1, 1'b0, 1'b0, v, 8'h00);
  endtask

  task automatic op(input logic [7:0] c);
    wait_idle();
    strobe(1'b0, 1'b1, 1'b0, 32'd0, c);
  endtask

  task automatic fin();
    wait_idle();
    strobe(1'b0, 1'b0, 1'b1, 32'd0, 8'h00);
  endtask

  task automatic expect_result(input string name, input logic [31:0] v);
    #1;
    check({name, "_n"}, 32'(got_res.size()), 32'd1);
    if (got_res.size() > 0) check(name, got_res[0], v);
    check({name, "_noerr"}, 32'(got_err.size()), 32'd0);
    got_res.delete();
    got_err.delete();
    @(negedge clk);
  endtask

  task automatic expect_err(input string name, input logic [2:0] c);
    #1;
    check({name, "_n"}, 32'(got_err.size()), 32'd1);
    if (got_err.size() > 0) check(name, 32'(got_err[0]), 32'(c));
    got_res.delete();
    got_err.delete();
    @(negedge clk);
  endtask

  task automatic expect_none(input string name);
    #1;
    check({name, "_res"}, 32'(got_res.size()), 32'd0);
    check({name, "_err"}, 32'(got_err.size()), 32'd0);
    got_res.delete();
    got_err.delete();
    @(negedge clk);
  endtask

  task automatic measure_busy(input string name, input int exp_cycles);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    num_data = '0; num_stb = 1'b0; op_code = '0; op_stb = 1'b0; end_stb = 1'b0;
    #12;
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_res",   result,          32'd0);
    check("rst_rstb",  32'(result_stb), 32'd0);
    check("rst_estb",  32'(err_stb),    32'd0);
    check("rst_ecode", 32'(err_code),   32'd0);
    check("rst_depth", 32'(depth_out),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // (3 + 4) * 2
    push(32'd3); push(32'd4); op("+"); push(32'd2); op("*"); fin();
    expect_result("expr_14", 32'd14);
    check("expr_depth0", 32'(depth_out), 32'd0);

    // 100 / 7 and 100 % 7
    push(32'd100); push(32'd7); op("/");
    measure_busy("div_busy", 32);
    fin();
    expect_result("div_q", 32'd14);
    push(32'd100); push(32'd7); op("%");
    measure_busy("mod_busy", 32);
    fin();
    expect_result("mod_r", 32'd2);

    // divide by zero, drain, recovery
    push(32'd5); push(32'd0); op("/");
    expect_err("err_divz", 3'd3);
    push(32'd1); op("+"); fin();
    expect_none("drain");
    push(32'd9); fin();
    expect_result("after_drain", 32'd9);

    // overflow at full depth
    for (int i = 0; i < 16; i++) push(32'(i + 1));
    check("full_depth", 32'(depth_out), 32'd16);
    push(32'd17);
    expect_err("err_over", 3'd2);
    fin();
    expect_none("over_drain");

    // underflow, bad operator, END at depth 2 (straight back to IDLE)
    push(32'd1); op("+");
    expect_err("err_under", 3'd1);
    fin();
    push(32'd1); push(32'd2); op("&");
    expect_err("err_badop", 3'd4);
    fin();
    push(32'd1); push(32'd2); fin();
    expect_err("err_end", 3'd5);
    push(32'd6); fin();
    expect_result("after_err5", 32'd6);

    // strobe collisions
    strobe(1'b1, 1'b1, 1'b0, 32'd3, "+");
    expect_err("err_multi", 3'd6);
    fin();
    expect_none("multi_drain");
    push(32'd8);
    strobe(1'b1, 1'b0, 1'b1, 32'd3, 8'h00);
    expect_err("err_multi_end", 3'd6);
    push(32'd4); fin();
    expect_result("after_multi_end", 32'd4);

    // strobes during BUSY are ignored
    push(32'd100); push(32'd7); op("/");
    strobe(1'b1, 1'b0, 1'b0, 32'd55, 8'h00);
    strobe(1'b0, 1'b1, 1'b0, 32'd0, "+");
    strobe(1'b0, 1'b0, 1'b1, 32'd0, 8'h00);
    check("busy_depth", 32'(depth_out), 32'd2);
    expect_none("busy_ignore");
    fin();
    expect_result("busy_div", 32'd14);

    // wraparound
    push(32'hFFFF_FFFF); push(32'd2); op("*"); fin();
    expect_result("mul_wrap", 32'hFFFF_FFFE);
    push(32'd0); push(32'd1); op("-"); fin();
    expect_result("sub_wrap", 32'hFFFF_FFFF);

    // reset in the middle of a divide (ERR_CODE is 6 and RESULT nonzero beforehand)
    push(32'd100); push(32'd7); op("/");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(busy),       32'd0);
    check("mid_rst_res",   result,          32'd0);
    check("mid_rst_rstb",  32'(result_stb), 32'd0);
    check("mid_rst_estb",  32'(err_stb),    32'd0);
    check("mid_rst_ecode", 32'(err_code),   32'd0);
    check("mid_rst_depth", 32'(depth_out),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    got_res.delete();
    got_err.delete();
    @(negedge clk);
    push(32'd20); push(32'd3); op("%"); fin();
    expect_result("after_rst", 32'd2);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
